// File: rtl/placar_pkg.sv
// Shared definitions for the collision scoreboard: FSM encoding,
// geometry width, seven-segment patterns and a BCD conversion helper.
package placar_pkg;

    typedef enum logic [1:0] {
        JOGANDO = 2'd0,
        IMUNE   = 2'd1,
        PERDEU  = 2'd2
    } estado_t;

    // Geometry sums are done at this width so that x + w - 1 + r never wraps.
    localparam int GEO_W = 12;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Converts an integer 0..9999 into four packed BCD digits.
    function automatic logic [15:0] int_para_bcd(input int valor);
        logic [15:0] bcd;
        bcd[3:0]   = 4'(valor % 10);
        bcd[7:4]   = 4'((valor / 10) % 10);
        bcd[11:8]  = 4'((valor / 100) % 10);
        bcd[15:12] = 4'((valor / 1000) % 10);
        return bcd;
    endfunction

endpackage

// File: rtl/placar_colisao_hex7seg.sv
// BCD digit to active-low seven-segment decoder; codes above 9 show blank.
module hex7seg
    import placar_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (digito_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/placar_colisao.sv
// Per-frame collision scoreboard: detects allied-ball/enemy and
// enemy-ball/ship hits, keeps BCD score, lives and game-over flag,
// and drives the seven-segment displays.
// Optional high-score register enabled by macro PLACAR_RECORDE_EN.
module placar_colisao
    import placar_pkg::*;
#(
    parameter int PONTOS_ACERTO  = 10,
    parameter int VIDAS_INICIAIS = 3,
    parameter int IMUNE_FRAMES   = 60
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pausa,
    input  logic        frame_tick,
    input  logic [9:0]  x_bola_aliada,
    input  logic [9:0]  y_bola_aliada,
    input  logic [9:0]  raio_bola_aliada,
    input  logic [9:0]  x_bola_inimiga,
    input  logic [9:0]  y_bola_inimiga,
    input  logic [9:0]  raio_bola_inimiga,
    input  logic [9:0]  x_nave,
    input  logic [9:0]  y_nave,
    input  logic [9:0]  largura_nave,
    input  logic [9:0]  altura_nave,
    input  logic [9:0]  x_inimigo,
    input  logic [9:0]  y_inimigo,
    input  logic [9:0]  largura_inimigo,
    input  logic [9:0]  altura_inimigo,
    output logic        acerto_inimigo,
    output logic        acerto_nave,
    output logic [15:0] pontos_bcd,
    output logic [1:0]  vidas,
    output logic        perdeu,
    output logic [15:0] recorde_bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam logic [15:0]      PONTOS_BCD = int_para_bcd(PONTOS_ACERTO);
    localparam logic [1:0]       VIDAS_RST  = 2'(VIDAS_INICIAIS);
    localparam logic [7:0]       IMUNE_INI  = 8'(IMUNE_FRAMES);
    localparam logic [GEO_W-1:0] UM         = 1;

    // Bounding square of the ball against the rectangle; zero-size never hits.
    function automatic logic sobrepoe(
        input logic [9:0] xb, input logic [9:0] yb, input logic [9:0] r,
        input logic [9:0] xr, input logic [9:0] yr,
        input logic [9:0] w,  input logic [9:0] h
    );
        logic [GEO_W-1:0] xb_e, yb_e, r_e, xr_e, yr_e, w_e, h_e;
        xb_e = GEO_W'(xb);
        yb_e = GEO_W'(yb);
        r_e  = GEO_W'(r);
        xr_e = GEO_W'(xr);
        yr_e = GEO_W'(yr);
        w_e  = GEO_W'(w);
        h_e  = GEO_W'(h);
        return (w != 10'd0) && (h != 10'd0) &&
               (xb_e + r_e >= xr_e) && (xb_e <= xr_e + w_e - UM + r_e) &&
               (yb_e + r_e >= yr_e) && (yb_e <= yr_e + h_e - UM + r_e);
    endfunction

    // Four-digit BCD addition with per-digit carry, clamped at 9999.
    function automatic logic [15:0] bcd_soma_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        logic [4:0]  s;
        logic        c;
        res = '0;
        c   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            res[4*i +: 4] = s[3:0];
        end
        return c ? 16'h9999 : res;
    endfunction

    estado_t     estado_q, estado_d;
    logic [15:0] pontos_q, pontos_d;
    logic [1:0]  vidas_q, vidas_d;
    logic [7:0]  imune_q, imune_d;
    logic        hist_ini_q, hist_ini_d;
    logic        hist_nave_q, hist_nave_d;
    logic        acerto_ini_q, acerto_ini_d;
    logic        acerto_nave_q, acerto_nave_d;

    logic avalia;
    logic sob_ini, sob_nave;
    logic conta_ini, conta_nave;

    assign avalia   = frame_tick & ~pausa;
    assign sob_ini  = sobrepoe(x_bola_aliada, y_bola_aliada, raio_bola_aliada,
                               x_inimigo, y_inimigo, largura_inimigo, altura_inimigo);
    assign sob_nave = sobrepoe(x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
                               x_nave, y_nave, largura_nave, altura_nave);
    // Only a rising overlap (absent at the previous evaluation) counts.
    assign conta_ini  = sob_ini & ~hist_ini_q;
    assign conta_nave = sob_nave & ~hist_nave_q;

    // Next-state logic: game FSM, score, lives, immunity and hit pulses.
    always_comb begin
        estado_d      = estado_q;
        pontos_d      = pontos_q;
        vidas_d       = vidas_q;
        imune_d       = imune_q;
        hist_ini_d    = hist_ini_q;
        hist_nave_d   = hist_nave_q;
        acerto_ini_d  = 1'b0;
        acerto_nave_d = 1'b0;
        if (avalia) begin
            hist_ini_d  = sob_ini;
            hist_nave_d = sob_nave;
            case (estado_q)
                JOGANDO: begin
                    if (conta_ini) begin
                        pontos_d     = bcd_soma_sat(pontos_q, PONTOS_BCD);
                        acerto_ini_d = 1'b1;
                    end
                    if (conta_nave) begin
                        vidas_d       = vidas_q - 2'd1;
                        acerto_nave_d = 1'b1;
                        if (vidas_q == 2'd1) begin
                            estado_d = PERDEU;
                        end else begin
                            estado_d = IMUNE;
                            imune_d  = IMUNE_INI;
                        end
                    end
                end
                IMUNE: begin
                    if (conta_ini) begin
                        pontos_d     = bcd_soma_sat(pontos_q, PONTOS_BCD);
                        acerto_ini_d = 1'b1;
                    end
                    if (imune_q <= 8'd1) begin
                        estado_d = JOGANDO;
                        imune_d  = 8'd0;
                    end else begin
                        imune_d = imune_q - 8'd1;
                    end
                end
                PERDEU: begin
                end
                default: estado_d = JOGANDO;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado_q      <= JOGANDO;
            pontos_q      <= 16'h0000;
            vidas_q       <= VIDAS_RST;
            imune_q       <= 8'd0;
            hist_ini_q    <= 1'b0;
            hist_nave_q   <= 1'b0;
            acerto_ini_q  <= 1'b0;
            acerto_nave_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            pontos_q      <= pontos_d;
            vidas_q       <= vidas_d;
            imune_q       <= imune_d;
            hist_ini_q    <= hist_ini_d;
            hist_nave_q   <= hist_nave_d;
            acerto_ini_q  <= acerto_ini_d;
            acerto_nave_q <= acerto_nave_d;
        end
    end

    assign acerto_inimigo = acerto_ini_q;
    assign acerto_nave    = acerto_nave_q;
    assign pontos_bcd     = pontos_q;
    assign vidas          = vidas_q;
    assign perdeu         = (estado_q == PERDEU);

`ifdef PLACAR_RECORDE_EN
    // Digit-by-digit BCD compare, most significant digit decides first.
    function automatic logic bcd_maior(input logic [15:0] a, input logic [15:0] b);
        logic maior, decidido;
        maior    = 1'b0;
        decidido = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decidido) begin
                if (a[4*i +: 4] > b[4*i +: 4]) begin
                    maior    = 1'b1;
                    decidido = 1'b1;
                end else if (a[4*i +: 4] < b[4*i +: 4]) begin
                    decidido = 1'b1;
                end
            end
        end
        return maior;
    endfunction

    // High score survives reset; the score is frozen in PERDEU so it is
    // captured on the cycle after game over.
    logic [15:0] recorde_q = 16'h0000;

    // Latch the final score when it beats the stored record.
    always_ff @(posedge CLOCK_50) begin
        if (estado_q == PERDEU && bcd_maior(pontos_q, recorde_q)) begin
            recorde_q <= pontos_q;
        end
    end

    assign recorde_bcd = recorde_q;
`else
    assign recorde_bcd = 16'h0000;
`endif

    hex7seg u_hex0 (.digito_i(pontos_q[3:0]),   .seg_o(HEX0));
    hex7seg u_hex1 (.digito_i(pontos_q[7:4]),   .seg_o(HEX1));
    hex7seg u_hex2 (.digito_i(pontos_q[11:8]),  .seg_o(HEX2));
    hex7seg u_hex3 (.digito_i(pontos_q[15:12]), .seg_o(HEX3));
    hex7seg u_hex5 (.digito_i({2'b00, vidas_q}), .seg_o(HEX5));

    assign HEX4 = SEG_BLANK;

endmodule

// File: tb/tb_placar_colisao.sv
// Directed bench for placar_colisao (default parameters 10 / 3 / 60).
module tb_placar_colisao;

    logic        clk;
    logic        reset;
    logic        pausa;
    logic        frame_tick;
    logic [9:0]  x_bola_aliada, y_bola_aliada, raio_bola_aliada;
    logic [9:0]  x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic [9:0]  x_nave, y_nave, largura_nave, altura_nave;
    logic [9:0]  x_inimigo, y_inimigo, largura_inimigo, altura_inimigo;
    logic        acerto_inimigo, acerto_nave;
    logic [15:0] pontos_bcd;
    logic [1:0]  vidas;
    logic        perdeu;
    logic [15:0] recorde_bcd;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int tests_run;
    int tests_failed;

    placar_colisao dut (
        .CLOCK_50(clk), .reset(reset), .pausa(pausa), .frame_tick(frame_tick),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
        .raio_bola_aliada(raio_bola_aliada),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
        .raio_bola_inimiga(raio_bola_inimiga),
        .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave),
        .altura_nave(altura_nave),
        .x_inimigo(x_inimigo), .y_inimigo(y_inimigo),
        .largura_inimigo(largura_inimigo), .altura_inimigo(altura_inimigo),
        .acerto_inimigo(acerto_inimigo), .acerto_nave(acerto_nave),
        .pontos_bcd(pontos_bcd), .vidas(vidas), .perdeu(perdeu),
        .recorde_bcd(recorde_bcd),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    // Clock and power-up input values.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b0;
        pausa      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame_tick pulse; returns at the negedge after the evaluating edge.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ally_on();
        x_bola_aliada = 10'd100;
        y_bola_aliada = 10'd100;
    endtask

    task automatic ally_off();
        x_bola_aliada = 10'd500;
        y_bola_aliada = 10'd500;
    endtask

    task automatic ball_on();
        x_bola_inimiga = 10'd310;
        y_bola_inimiga = 10'd405;
    endtask

    task automatic ball_off();
        x_bola_inimiga = 10'd600;
        y_bola_inimiga = 10'd50;
    endtask

    // n separated enemy hits (overlap frame followed by a clear frame).
    task automatic enemy_hits(input int n);
        repeat (n) begin
            ally_on();
            tick();
            ally_off();
            tick();
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        repeat (3) tick();
        tests_run++;
        if (pontos_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_pontos: got %h expected 0000", pontos_bcd);
        end
        tests_run++;
        if (vidas !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_vidas: got %0d expected 3", vidas);
        end
        tests_run++;
        if (perdeu !== 1'b0 || acerto_inimigo !== 1'b0 || acerto_nave !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got perdeu=%b ai=%b an=%b expected 0 0 0",
                     perdeu, acerto_inimigo, acerto_nave);
        end
        tests_run++;
        if (HEX5 !== 7'b0110000 || HEX4 !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL reset_hex54: got %b %b expected 0110000 1111111", HEX5, HEX4);
        end
        tests_run++;
        if (HEX0 !== 7'b1000000 || HEX3 !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL reset_hex30: got %b %b expected 1000000 1000000", HEX3, HEX0);
        end
        tests_run++;
        if (recorde_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_recorde: got %h expected 0000", recorde_bcd);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        // x_b + r == x_r exactly, but zero width: no hit.
        x_bola_aliada   = 10'd86;
        y_bola_aliada   = 10'd100;
        largura_inimigo = 10'd0;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b0 || pontos_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL bound_w0: got ai=%b pts=%h expected 0 0000", acerto_inimigo, pontos_bcd);
        end
        // Same position, real width: left-edge touch counts.
        largura_inimigo = 10'd16;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b1 || pontos_bcd !== 16'h0010) begin
            tests_failed++;
            $display("FAIL bound_left: got ai=%b pts=%h expected 1 0010", acerto_inimigo, pontos_bcd);
        end
        // One pixel further left: no overlap.
        x_bola_aliada = 10'd85;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b0 || pontos_bcd !== 16'h0010) begin
            tests_failed++;
            $display("FAIL bound_left_out: got ai=%b pts=%h expected 0 0010", acerto_inimigo, pontos_bcd);
        end
        // Right edge: x_b == x_r + w - 1 + r = 109 touches.
        x_bola_aliada = 10'd109;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b1 || pontos_bcd !== 16'h0020) begin
            tests_failed++;
            $display("FAIL bound_right: got ai=%b pts=%h expected 1 0020", acerto_inimigo, pontos_bcd);
        end
        x_bola_aliada = 10'd110;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b0 || pontos_bcd !== 16'h0020) begin
            tests_failed++;
            $display("FAIL bound_right_out: got ai=%b pts=%h expected 0 0020", acerto_inimigo, pontos_bcd);
        end
        ally_off();
    endtask

    task automatic test_enemy_hit();
        int pulses;
        do_reset();
        pulses = 0;
        ally_on();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acerto_inimigo === 1'b1) pulses++;
            if (i == 0) begin
                tests_run++;
                if (pontos_bcd !== 16'h0010) begin
                    tests_failed++;
                    $display("FAIL hit_first: got %h expected 0010", pontos_bcd);
                end
                @(negedge clk);
                tests_run++;
                if (acerto_inimigo !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hit_pulse_width: got %b expected 0", acerto_inimigo);
                end
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL hit_held_pulses: got %0d expected 1", pulses);
        end
        tests_run++;
        if (pontos_bcd !== 16'h0010) begin
            tests_failed++;
            $display("FAIL hit_held_score: got %h expected 0010", pontos_bcd);
        end
        ally_off();
        tick();
    endtask

    task automatic test_bcd_carry();
        do_reset();
        enemy_hits(92);
        tests_run++;
        if (pontos_bcd !== 16'h0920) begin
            tests_failed++;
            $display("FAIL bcd_0920: got %h expected 0920", pontos_bcd);
        end
        enemy_hits(8);
        tests_run++;
        if (pontos_bcd !== 16'h1000 || HEX3 !== 7'b1111001 || HEX2 !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL bcd_1000: got %h hex3=%b hex2=%b expected 1000 1111001 1000000",
                     pontos_bcd, HEX3, HEX2);
        end
        enemy_hits(899);
        tests_run++;
        if (pontos_bcd !== 16'h9990) begin
            tests_failed++;
            $display("FAIL bcd_9990: got %h expected 9990", pontos_bcd);
        end
        enemy_hits(1);
        tests_run++;
        if (pontos_bcd !== 16'h9999) begin
            tests_failed++;
            $display("FAIL bcd_sat1: got %h expected 9999", pontos_bcd);
        end
        enemy_hits(1);
        tests_run++;
        if (pontos_bcd !== 16'h9999) begin
            tests_failed++;
            $display("FAIL bcd_sat2: got %h expected 9999", pontos_bcd);
        end
    endtask

    task automatic test_ship_immunity();
        do_reset();
        ball_on();
        tick();                               // evaluation 0: counted
        tests_run++;
        if (acerto_nave !== 1'b1 || vidas !== 2'd2) begin
            tests_failed++;
            $display("FAIL ship_first: got an=%b vidas=%0d expected 1 2", acerto_nave, vidas);
        end
        ball_off();
        tick();                               // evaluation 1
        ball_on();
        tick();                               // evaluation 2: immune
        tests_run++;
        if (acerto_nave !== 1'b0 || vidas !== 2'd2) begin
            tests_failed++;
            $display("FAIL ship_immune: got an=%b vidas=%0d expected 0 2", acerto_nave, vidas);
        end
        ball_off();
        repeat (57) tick();                   // evaluations 3..59
        ball_on();
        tick();                               // evaluation 60: still immune
        tests_run++;
        if (acerto_nave !== 1'b0 || vidas !== 2'd2) begin
            tests_failed++;
            $display("FAIL ship_immune_last: got an=%b vidas=%0d expected 0 2", acerto_nave, vidas);
        end
        ball_off();
        tick();
        ball_on();
        tick();                               // fresh touch after immunity
        tests_run++;
        if (acerto_nave !== 1'b1 || vidas !== 2'd1 || HEX5 !== 7'b1111001) begin
            tests_failed++;
            $display("FAIL ship_second: got an=%b vidas=%0d hex5=%b expected 1 1 1111001",
                     acerto_nave, vidas, HEX5);
        end
    endtask

    // Continues from one remaining life in immunity.
    task automatic test_game_over();
        ball_off();
        tick();
        enemy_hits(12);
        repeat (60) tick();
        tests_run++;
        if (pontos_bcd !== 16'h0120 || perdeu !== 1'b0) begin
            tests_failed++;
            $display("FAIL over_pre: got pts=%h perdeu=%b expected 0120 0", pontos_bcd, perdeu);
        end
        ball_on();
        tick();
        tests_run++;
        if (acerto_nave !== 1'b1 || vidas !== 2'd0 || perdeu !== 1'b1) begin
            tests_failed++;
            $display("FAIL over_enter: got an=%b vidas=%0d perdeu=%b expected 1 0 1",
                     acerto_nave, vidas, perdeu);
        end
        ball_off();
        ally_on();
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b0 || pontos_bcd !== 16'h0120) begin
            tests_failed++;
            $display("FAIL over_frozen_score: got ai=%b pts=%h expected 0 0120", acerto_inimigo, pontos_bcd);
        end
        ally_off();
        ball_on();
        tick();
        tests_run++;
        if (acerto_nave !== 1'b0 || vidas !== 2'd0 || perdeu !== 1'b1) begin
            tests_failed++;
            $display("FAIL over_frozen_life: got an=%b vidas=%0d perdeu=%b expected 0 0 1",
                     acerto_nave, vidas, perdeu);
        end
        ball_off();
        do_reset();
        tests_run++;
        if (vidas !== 2'd3 || perdeu !== 1'b0 || pontos_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL over_reset: got vidas=%0d perdeu=%b pts=%h expected 3 0 0000",
                     vidas, perdeu, pontos_bcd);
        end
`ifdef PLACAR_RECORDE_EN
        tests_run++;
        if (recorde_bcd !== 16'h0120) begin
            tests_failed++;
            $display("FAIL over_recorde: got %h expected 0120", recorde_bcd);
        end
`else
        tests_run++;
        if (recorde_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL over_recorde: got %h expected 0000", recorde_bcd);
        end
`endif
    endtask

    task automatic test_pause();
        do_reset();
        ally_on();
        ball_on();
        pausa = 1'b1;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b0 || acerto_nave !== 1'b0 ||
            pontos_bcd !== 16'h0000 || vidas !== 2'd3) begin
            tests_failed++;
            $display("FAIL pause_frozen: got ai=%b an=%b pts=%h vidas=%0d expected 0 0 0000 3",
                     acerto_inimigo, acerto_nave, pontos_bcd, vidas);
        end
        pausa = 1'b0;
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b1 || acerto_nave !== 1'b1 ||
            pontos_bcd !== 16'h0010 || vidas !== 2'd2) begin
            tests_failed++;
            $display("FAIL pause_resume_both: got ai=%b an=%b pts=%h vidas=%0d expected 1 1 0010 2",
                     acerto_inimigo, acerto_nave, pontos_bcd, vidas);
        end
    endtask

    // Reset while immune with overlaps still present clears history and immunity.
    task automatic test_reset_mid();
        do_reset();
        tests_run++;
        if (vidas !== 2'd3 || pontos_bcd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_values: got vidas=%0d pts=%h expected 3 0000", vidas, pontos_bcd);
        end
        tick();
        tests_run++;
        if (acerto_inimigo !== 1'b1 || acerto_nave !== 1'b1 || vidas !== 2'd2) begin
            tests_failed++;
            $display("FAIL midreset_recount: got ai=%b an=%b vidas=%0d expected 1 1 2",
                     acerto_inimigo, acerto_nave, vidas);
        end
        ally_off();
        ball_off();
    endtask

    // Sequencer and final report.
    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        pausa             = 1'b0;
        frame_tick        = 1'b0;
        raio_bola_aliada  = 10'd4;
        raio_bola_inimiga = 10'd3;
        x_nave            = 10'd300;
        y_nave            = 10'd400;
        largura_nave      = 10'd32;
        altura_nave       = 10'd16;
        x_inimigo         = 10'd90;
        y_inimigo         = 10'd90;
        largura_inimigo   = 10'd16;
        altura_inimigo    = 10'd16;
        ally_off();
        ball_off();

        test_reset();
        test_boundary();
        test_enemy_hit();
        test_bcd_carry();
        test_ship_immunity();
        test_game_over();
        test_pause();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
